// File: rtl/ser_tx_pkg.sv
// rtl/ser_tx_pkg.sv - shared FSM state and shifter select encodings for ser_tx_arb
package ser_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_LOAD  = 2'b01;
    localparam logic [1:0] SEL_SHIFT = 2'b10;
    localparam logic [1:0] SEL_CLR   = 2'b11;

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - WIDTH-bit parallel-load, right-shift register with 2-bit select
module shift_core
    import ser_tx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       i_sel,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit0
);

    logic [WIDTH-1:0] r_q;

    // Hold, load, shift toward bit 0 with zero fill, or clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            case (i_sel)
                SEL_LOAD:  r_q <= i_data;
                SEL_SHIFT: r_q <= r_q >> 1;
                SEL_CLR:   r_q <= '0;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign o_bit0 = r_q[0];

endmodule

// File: rtl/ser_tx_arb.sv
// rtl/ser_tx_arb.sv - round-robin arbiter feeding one LSB-first serial shifter
module ser_tx_arb
    import ser_tx_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 4,
    localparam int OW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    input  logic                  abort,
    output logic [NREQ-1:0]       ack,
    output logic [OW-1:0]         owner,
    output logic                  sout,
    output logic                  sout_valid,
    output logic                  frame_last,
    output logic                  busy
);

    state_t          r_state;
    logic [CW-1:0]   r_bit_cnt;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   r_last_owner;
    logic [NREQ-1:0] r_ack;

    logic             w_any;
    logic             w_last_bit;
    logic             w_grant;
    logic             w_found;
    logic [OW-1:0]    w_winner;
    logic [OW-1:0]    w_idx;
    logic [WIDTH-1:0] w_word;
    logic [1:0]       w_sel;
    logic             w_bit0;

    assign w_any      = |req;
    assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_cnt == CW'(WIDTH - 1));
    // A new frame may start from IDLE or on the edge that ends the final bit
    assign w_grant    = !abort && w_any && ((r_state == ST_IDLE) || w_last_bit);
    assign w_word     = data[int'(w_winner)*WIDTH +: WIDTH];

    // Round-robin search upward starting just after the previous owner
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = OW'((int'(r_last_owner) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Shifter select: abort clears, a grant loads, an active frame shifts
    always_comb begin
        w_sel = SEL_HOLD;
        if (abort) begin
            w_sel = SEL_CLR;
        end else if (w_grant) begin
            w_sel = SEL_LOAD;
        end else if (r_state == ST_SHIFT) begin
            w_sel = SEL_SHIFT;
        end
    end

    shift_core #(
        .WIDTH (WIDTH)
    ) u_shift_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sel  (w_sel),
        .i_data (w_word),
        .o_bit0 (w_bit0)
    );

    // Two-state frame FSM with bit counter, ownership and the ack pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_owner      <= '0;
            r_last_owner <= OW'(NREQ - 1);
            r_ack        <= '0;
        end else begin
            r_ack <= '0;
            if (abort) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
            end else if (w_grant) begin
                r_state      <= ST_SHIFT;
                r_bit_cnt    <= '0;
                r_owner      <= w_winner;
                r_last_owner <= w_winner;
                r_ack        <= NREQ'(1) << w_winner;
            end else if (r_state == ST_SHIFT) begin
                if (w_last_bit) begin
                    r_state   <= ST_IDLE;
                    r_bit_cnt <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end
        end
    end

    assign ack        = r_ack;
    assign owner      = r_owner;
    assign sout_valid = (r_state == ST_SHIFT);
    assign sout       = (r_state == ST_SHIFT) && w_bit0;
    assign frame_last = w_last_bit;
    assign busy       = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_ser_tx_arb.sv
// tb/tb_ser_tx_arb.sv - self-checking bench for ser_tx_arb
module tb_ser_tx_arb;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic           abort;
    logic [N-1:0]   ack;
    logic [1:0]     owner;
    logic           sout;
    logic           sout_valid;
    logic           frame_last;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit auto_drop;

    int q_bits[$];
    int q_fl[$];
    int q_own[$];
    int q_cyc[$];

    bit           m_busy;
    int           m_idx;
    int           m_owner;
    int           m_last;
    logic [W-1:0] m_word;
    logic [N-1:0] m_ack;

    ser_tx_arb #(.NREQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data       (data),
        .abort      (abort),
        .ack        (ack),
        .owner      (owner),
        .sout       (sout),
        .sout_valid (sout_valid),
        .frame_last (frame_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int q[$], input int ew);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < q.size(); i++) begin
            v = v | (64'(q[i]) << (i * ew));
        end
        return v;
    endfunction

    // Frame-level model: a frame is (owner, word, bit index), bits read by index
    always @(posedge clk or negedge rst_n) begin
        int pick;
        int c;
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_idx   = 0;
            m_owner = 0;
            m_last  = N - 1;
            m_word  = '0;
            m_ack   = '0;
        end else begin
            m_ack = '0;
            if (abort) begin
                m_busy = 1'b0;
                m_idx  = 0;
            end else if (!m_busy || m_idx == W - 1) begin
                pick = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (pick < 0 && req[c]) pick = c;
                end
                if (pick >= 0) begin
                    m_busy      = 1'b1;
                    m_idx       = 0;
                    m_owner     = pick;
                    m_last      = pick;
                    m_word      = data[pick*W +: W];
                    m_ack[pick] = 1'b1;
                end else begin
                    m_busy = 1'b0;
                    m_idx  = 0;
                end
            end else begin
                m_idx++;
            end
        end
    end

    // Per-cycle comparison against the model plus logging of the serial stream
    always begin
        logic exp_sout;
        @(posedge clk);
        #2;
        cyc++;
        exp_sout = m_busy ? m_word[m_idx] : 1'b0;
        chk("cycle", {ack, owner, sout, sout_valid, frame_last, busy},
            {m_ack, 2'(m_owner), exp_sout, m_busy, (m_busy && m_idx == W - 1), m_busy});
        if (sout_valid === 1'b1) begin
            q_bits.push_back(int'(sout));
            q_fl.push_back(int'(frame_last));
            q_cyc.push_back(cyc);
        end
        if (|ack) q_own.push_back(int'(owner));
    end

    task automatic tick();
        @(negedge clk);
        if (auto_drop) req = req & ~ack;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        q_bits.delete();
        q_fl.delete();
        q_own.delete();
        q_cyc.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        data      = '0;
        abort     = 1'b0;
        auto_drop = 1'b1;
        #3;
        chk("reset_outputs", {ack, owner, sout, sout_valid, frame_last, busy}, 64'h0);
        ticks(2);
        rst_n = 1'b1;

        // Single frame from requester 0
        data[3:0] = 4'b1011;
        clear_logs();
        req = 4'b0001;
        tick();
        chk("t1_ack", ack, 64'h1);
        ticks(7);
        chk("t1_nbits", q_bits.size(), 4);
        chk("t1_bits", pack(q_bits, 1), 64'b1011);
        chk("t1_last", pack(q_fl, 1), 64'b1000);
        chk("t1_owners", pack(q_own, 2), 64'h0);
        chk("t1_idle", busy, 64'h0);

        // All four requesting: back-to-back rotation from reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        auto_drop = 1'b0;
        data = {4'hC, 4'h3, 4'hA, 4'h5};
        clear_logs();
        req = 4'hF;
        ticks(17);
        req = 4'h0;
        ticks(6);
        auto_drop = 1'b1;
        chk("t2_nown", q_own.size(), 5);
        chk("t2_owners", pack(q_own, 2), 64'h0E4);
        chk("t2_nbits", q_bits.size(), 20);
        chk("t2_bits", pack(q_bits, 1), 64'h5C3A5);
        if (q_cyc.size() == 20) chk("t2_contig", q_cyc[19] - q_cyc[0], 19);
        else chk("t2_contig_len", q_cyc.size(), 20);

        // Owner 2 completes, then 0 and 2 request together
        clear_logs();
        req = 4'b0100;
        ticks(8);
        req = 4'b0101;
        ticks(12);
        chk("t3_owners", pack(q_own, 2), 64'h22);
        chk("t3_nown", q_own.size(), 3);

        // Abort on the second bit of requester 1's frame
        data[7:4] = 4'b0110;
        clear_logs();
        req = 4'b0010;
        tick();
        tick();
        abort = 1'b1;
        tick();
        chk("t4_abort_outs", {ack, sout, sout_valid, frame_last, busy}, 64'h0);
        abort = 1'b0;
        ticks(2);
        chk("t4_nbits", q_bits.size(), 2);
        chk("t4_bits", pack(q_bits, 1), 64'b10);
        chk("t4_nolast", pack(q_fl, 1), 64'h0);
        clear_logs();
        req = 4'b0010;
        ticks(7);
        chk("t4_reown", pack(q_own, 2), 64'h1);
        chk("t4_rebits", pack(q_bits, 1), 64'b0110);

        // Asynchronous reset mid-frame
        data[11:8] = 4'b1001;
        clear_logs();
        req = 4'b0100;
        ticks(2);
        chk("t5_owner_pre", owner, 64'h2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_outs", {ack, owner, sout, sout_valid, frame_last, busy}, 64'h0);
        tick();
        rst_n = 1'b1;
        data[7:4] = 4'b0011;
        clear_logs();
        req = 4'b0010;
        ticks(7);
        chk("t5_owner", pack(q_own, 2), 64'h1);
        chk("t5_bits", pack(q_bits, 1), 64'b0011);
        chk("t5_nbits", q_bits.size(), 4);

        // Abort together with a request in IDLE suppresses the grant
        clear_logs();
        req = 4'b0001;
        abort = 1'b1;
        tick();
        chk("t6_noack", {ack, busy}, 64'h0);
        abort = 1'b0;
        tick();
        chk("t6_grant", {ack, owner, busy}, {4'b0001, 2'd0, 1'b1});
        ticks(6);
        chk("t6_owners", q_own.size(), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ser_tx_arb.md
SER_TX_ARB -- requirements
Module: ser_tx_arb

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the serial shifter.
REQ-002 Parameter: WIDTH, 4, bits per frame, i.e. the parallel word width.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req  input  NREQ  per-requester transmit request, level.
REQ-006 Port: data  input  NREQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH].
REQ-007 Port: abort  input  1  synchronous frame abort and shifter clear.
REQ-008 Port: ack  output  NREQ  one-hot, one-cycle pulse: word of that requester captured.
REQ-009 Port: owner  output  clog2(NREQ)  index of the requester whose frame is on sout.
REQ-010 Port: sout  output  1  serial data, LSB first.
REQ-011 Port: sout_valid  output  1  sout carries a frame bit this cycle.
REQ-012 Port: frame_last  output  1  high during the final bit of a normally completing frame.
REQ-013 Port: busy  output  1  FSM not in IDLE.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and SHIFT.
REQ-015 The shifter SHALL be driven by a 2-bit select: 00 hold, 01 parallel load, 10 shift right with 0 into MSB, 11 clear.
REQ-016 In IDLE with any req high, the clock edge SHALL load the winner's word, set owner, pulse ack[winner] for the following cycle, clear bit_cnt, and enter SHIFT.
REQ-017 Winner selection SHALL be round-robin, searching upward from (last_owner+1) mod NREQ.
REQ-018 In SHIFT, sout SHALL equal shifter bit 0 and sout_valid SHALL be 1.
REQ-019 Each edge in SHIFT SHALL shift the register and increment bit_cnt, giving exactly WIDTH valid bits per frame.
REQ-020 frame_last SHALL be 1 while in SHIFT with bit_cnt == WIDTH-1.
REQ-021 On the edge ending the last bit, if any req is high, the next winner SHALL be loaded directly with no idle gap; otherwise the FSM SHALL return to IDLE.
REQ-022 Latency from the capturing edge to the first valid bit SHALL be 0 cycles; the first bit is visible in the cycle after that edge.
REQ-023 A requester SHALL hold req and data stable until it sees ack; requests without ack SHALL remain pending indefinitely.
REQ-024 A req still high in the cycle ack is seen SHALL be treated as a new request.
REQ-025 abort SHALL take priority over all other inputs: clear the shifter (select 11), enter IDLE, and force sout_valid=0 and frame_last=0 next cycle.
REQ-026 abort SHALL generate no ack and SHALL leave last_owner unchanged.
REQ-027 abort high in IDLE together with req SHALL suppress the grant that cycle.
REQ-028 In IDLE, sout SHALL be 0, sout_valid 0, and the shifter held.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately set state=IDLE, shifter=0, bit_cnt=0, owner=0, ack=0, sout=0, sout_valid=0, frame_last=0, busy=0, and last_owner=NREQ-1, so requester 0 has first priority.
REQ-030 Reset asserted mid-frame SHALL drop the frame with no further output bits; release SHALL occur cleanly to IDLE.

Structure
REQ-031 A shared package ser_tx_pkg SHALL hold the state enum and the SEL_HOLD/SEL_LOAD/SEL_SHIFT/SEL_CLR constants.
REQ-032 The WIDTH-bit shifter with its select mux SHALL be a sub-module named shift_core; the arbitration, FSM and counters SHALL be in ser_tx_arb.

Verification
REQ-033 After reset, req=0001 with data0=4'b1011: ack[0] pulses 1 cycle after the edge; sout = 1,1,0,1 with sout_valid on 4 cycles; frame_last on the 4th; then IDLE.
REQ-034 req=1111 held, all data distinct: owners go 0,1,2,3,0 with back-to-back frames and sout_valid continuously 1.
REQ-035 After owner 2 completes, req=0101: next owner is 0 (search starts at 3).
REQ-036 abort on the 2nd bit of a frame: sout_valid=0 next cycle, no frame_last, shifter reads 0; the same requester wins again if it re-requests.
REQ-037 rst_n driven low asynchronously mid-frame: all outputs reach reset values without a clock edge; after release, req=0010 produces owner 1 and a complete frame.
REQ-038 abort and req=0001 asserted together in IDLE: no ack that cycle; the grant occurs on the first edge after abort drops.
